// File: rtl/spi_multi_master.sv
// spi_multi_master: full-duplex SPI master with runtime slave select, clock divider and CPOL/CPHA.
module spi_multi_master #(
    parameter int NUM_SS = 4,
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_SS-1:0] spi_ss_n
);
    localparam int HW = $clog2(2 * DATA_W);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DATA_W - 1);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;
    state_t state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [HW-1:0] half_q, half_d, k;
    logic [DATA_W-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
    logic sclk_q, sclk_d, mosi_q, mosi_d, cpha_q, cpha_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic last, tick, lead;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            half_q  <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cpha_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ss_n_q  <= '1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            tx_q    <= tx_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cpha_q  <= cpha_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ss_n_q  <= ss_n_d;
        end
    end
    // tick marks the clk cycle that opens half-period k of the transfer: SCLK toggles there
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q + 1'b1;
        half_d  = half_q;
        tx_d    = tx_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cpha_d  = cpha_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ss_n_d  = ss_n_q;
        last    = cnt_q == div_q;
        k       = (state_q == SETUP) ? '0 : half_q + 1'b1;
        lead    = ~k[0];
        tick    = last && (state_q == SETUP || (state_q == XFER && half_q != LAST_HALF));
        if (last) cnt_d = '0;
        case (state_q)
            IDLE: if (start && int'(ss_sel) < NUM_SS) begin
                state_d = SETUP;
                div_d   = clk_div;
                cnt_d   = '0;
                tx_d    = tx_data;
                sclk_d  = cpol;
                cpha_d  = cpha;
                busy_d  = 1'b1;
                ss_n_d  = ~(NUM_SS'(1) << ss_sel);
                mosi_d  = cpha ? mosi_q : tx_data[DATA_W-1];
            end
            SETUP: state_d = last ? XFER : SETUP;
            XFER: state_d = (last && half_q == LAST_HALF) ? HOLD : XFER;
            HOLD: if (last) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                ss_n_d  = '1;
                rx_d    = rx_sh_q;
            end
            default: state_d = IDLE;
        endcase
        if (tick) begin
            half_d = k;
            sclk_d = ~sclk_q;
            if (lead ^ cpha_q) rx_sh_d = {rx_sh_q[DATA_W-2:0], spi_miso};
            if (cpha_q ? lead : (!lead && k != LAST_HALF)) begin
                mosi_d = cpha_q ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
                tx_d   = tx_q << 1;
            end
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign rx_data  = rx_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_ss_n = ss_n_q;
endmodule

// File: tb/tb_spi_multi_master.sv
// tb_spi_multi_master: directed transfers checked every cycle against a cycle-count model of the SPI master.
`timescale 1ns/1ps
module tb_spi_multi_master;
    localparam int NUM_SS = 4, DW = 16, DIV_W = 8, SEL_W = 3;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0;
    logic [SEL_W-1:0] ss_sel = '0;
    logic [DW-1:0] tx_data = '0;
    logic [DIV_W-1:0] clk_div = '0;
    logic busy, done, spi_sclk, spi_mosi, spi_miso;
    logic [DW-1:0] rx_data;
    logic [NUM_SS-1:0] spi_ss_n;
    int n_cmp = 0, n_bad = 0;
    always #10 clk = ~clk;
    spi_multi_master #(.NUM_SS(NUM_SS), .DATA_W(DW), .DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .start(start), .ss_sel(ss_sel), .tx_data(tx_data),
        .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .busy(busy), .done(done),
        .rx_data(rx_data), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_ss_n(spi_ss_n)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    // Slave: loopback from MOSI, or shifts out s_word following SCLK edges seen while selected
    logic loop = 1'b1;
    logic [DW-1:0] s_word = '0;
    int s_edges = 0;
    logic s_last = 1'b0;
    always @(spi_sclk or spi_ss_n or cpol) begin
        if (&spi_ss_n) begin
            s_edges = 0;
            s_last = cpol;
        end else if (spi_sclk !== s_last) begin
            s_edges++;
            s_last = spi_sclk;
        end
    end
    always_comb begin
        int b;
        b = cpha ? ((s_edges == 0) ? 0 : (s_edges - 1) / 2) : s_edges / 2;
        if (b > DW - 1) b = DW - 1;
        spi_miso = loop ? spi_mosi : s_word[DW-1-b];
    end
    // Model: a transfer is a cycle count n since acceptance; everything follows from n and H
    int m_n = 0, m_H = 1;
    logic m_act = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_fresh = 1'b1, run = 1'b0;
    logic [SEL_W-1:0] m_sel = '0;
    logic [DW-1:0] m_tx = '0, m_exp = '0, m_rx = '0;
    function automatic int span();
        return (2 * DW + 2) * m_H;
    endfunction
    always @(posedge clk) begin
        run = 1'b1;
        if (reset) begin
            m_act = 1'b0; m_n = 0; m_rx = '0; m_cpol = 1'b0; m_fresh = 1'b1;
        end else if ((!m_act || m_n > span()) && start && int'(ss_sel) < NUM_SS) begin
            m_act = 1'b1; m_n = 1; m_H = int'(clk_div) + 1; m_cpol = cpol; m_cpha = cpha;
            m_sel = ss_sel; m_tx = tx_data; m_exp = loop ? tx_data : s_word; m_fresh = 1'b0;
        end else if (m_act) begin
            m_n++;
            if (m_n == span() + 1) m_rx = m_exp;
            if (m_n > span() + 1) m_act = 1'b0;
        end
    end
    always @(negedge clk) if (run) begin
        logic e_busy, e_done, e_sclk, e_mosi, mdef;
        logic [NUM_SS-1:0] e_ss;
        int k, idx;
        e_busy = m_act && m_n <= span();
        e_done = m_act && m_n == span() + 1;
        e_ss = e_busy ? ~(NUM_SS'(1) << m_sel) : '1;
        e_sclk = m_cpol;
        idx = DW - 1;
        mdef = e_busy && (!m_cpha || m_n > m_H);
        if (e_busy && m_n > m_H && m_n <= m_H * (2 * DW + 1)) begin
            k = (m_n - 1 - m_H) / m_H;
            e_sclk = m_cpol ^ (k % 2 == 0);
            idx = m_cpha ? k / 2 : (((k + 1) / 2 > DW - 1) ? DW - 1 : (k + 1) / 2);
        end else if (e_busy && m_n <= m_H) idx = 0;
        e_mosi = m_tx[DW-1-idx];
        if (m_fresh) begin
            mdef = 1'b1;
            e_mosi = 1'b0;
        end
        chk("outputs{busy,done,ss_n,sclk,mosi,rx}",
            {8'b0, busy, done, spi_ss_n, spi_sclk, spi_mosi & mdef, rx_data},
            {8'b0, e_busy, e_done, e_ss, e_sclk, e_mosi & mdef, m_rx});
    end
    task automatic launch(input logic [SEL_W-1:0] sel, input logic [DW-1:0] tx,
                          input logic [DIV_W-1:0] dv, input logic pol, input logic pha);
        @(negedge clk);
        ss_sel = sel; tx_data = tx; clk_div = dv; cpol = pol; cpha = pha; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wait_done(input int lim, input logic [NUM_SS-1:0] ss_exp,
                             output int dc, output int bc, output int pulses, output logic ss_ok);
        logic prev;
        dc = -1; bc = 0; pulses = 0; ss_ok = 1'b1; prev = spi_sclk;
        for (int c = 1; c <= lim; c++) begin
            if (done) begin
                dc = c;
                break;
            end
            if (busy) bc++;
            if (busy && spi_ss_n !== ss_exp) ss_ok = 1'b0;
            if (spi_sclk != cpol && prev == cpol) pulses++;
            prev = spi_sclk;
            @(negedge clk);
        end
    endtask
    initial begin
        int dc, bc, pl, nd;
        logic ok, any_busy, any_ss;
        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, spi_ss_n, spi_sclk, spi_mosi, rx_data}, {2'b00, 4'hF, 2'b00, 16'h0});
        reset = 1'b0;
        loop = 1'b1;
        launch(3'd2, 16'hA5C3, 8'd1, 1'b0, 1'b0);
        wait_done(200, 4'b1011, dc, bc, pl, ok);
        chk("m0_done_cycle", dc, 69);
        chk("m0_busy_cycles", bc, 68);
        chk("m0_sclk_pulses", pl, 16);
        chk("m0_ss_n_1011", {31'b0, ok}, 1);
        chk("m0_rx", rx_data, 16'hA5C3);
        loop = 1'b0; s_word = 16'h3C5A;
        launch(3'd1, 16'h0F0F, 8'd0, 1'b1, 1'b1);
        wait_done(200, 4'b1101, dc, bc, pl, ok);
        chk("m3_done_cycle", dc, 35);
        chk("m3_busy_cycles", bc, 34);
        chk("m3_sclk_pulses", pl, 16);
        chk("m3_ss_n_1101", {31'b0, ok}, 1);
        chk("m3_rx", rx_data, 16'h3C5A);
        chk("m3_sclk_idle", {31'b0, spi_sclk}, 1);
        loop = 1'b1;
        launch(3'd3, 16'h1234, 8'd0, 1'b0, 1'b0);
        nd = 0;
        for (int c = 1; c <= 80; c++) begin
            if (done) nd++;
            start = (c == 5 || c == 20);
            tx_data = 16'hFFFF; ss_sel = 3'd0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("restart_done_pulses", nd, 1);
        chk("restart_rx", rx_data, 16'h1234);
        @(negedge clk);
        ss_sel = 3'd0; tx_data = 16'h8001; clk_div = 8'd0; cpol = 1'b0; cpha = 1'b1; start = 1'b1;
        @(negedge clk);
        wait_done(100, 4'b1110, dc, bc, pl, ok);
        chk("b2b_first_done", dc, 35);
        chk("b2b_done_cycle_ss_busy", {busy, spi_ss_n}, {1'b0, 4'b1111});
        @(negedge clk);
        start = 1'b0;
        chk("b2b_restart_ss_busy", {busy, spi_ss_n}, {1'b1, 4'b1110});
        wait_done(100, 4'b1110, dc, bc, pl, ok);
        chk("b2b_second_done", dc, 35);
        chk("b2b_ss_low", {31'b0, ok}, 1);
        chk("b2b_rx", rx_data, 16'h8001);
        loop = 1'b0; s_word = 16'h5555;
        launch(3'd1, 16'hBEEF, 8'd1, 1'b1, 1'b0);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_xfer", {busy, done, spi_ss_n, spi_sclk, rx_data}, {2'b00, 4'hF, 1'b0, 16'h0});
        reset = 1'b0;
        nd = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("reset_no_done", nd, 0);
        ss_sel = 3'd5; tx_data = 16'hAAAA; start = 1'b1;
        nd = 0; any_busy = 1'b0; any_ss = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 10) start = 1'b0;
            if (done) nd++;
            any_busy |= busy;
            any_ss |= ~&spi_ss_n;
        end
        chk("badsel_busy", {31'b0, any_busy}, 0);
        chk("badsel_ss", {31'b0, any_ss}, 0);
        chk("badsel_done", nd, 0);
        s_word = 16'hC001;
        launch(3'd0, 16'h6B2D, 8'd2, 1'b1, 1'b0);
        wait_done(200, 4'b1110, dc, bc, pl, ok);
        chk("m2_done_cycle", dc, 103);
        chk("m2_sclk_pulses", pl, 16);
        chk("m2_rx", rx_data, 16'hC001);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
